up16_run_monitor: RTL and testbench
===================================

// Module: up16_run_monitor
// PURPOSE
// - Parametrised run controller and trace monitor for the uP16 pipelined core; successor to the fixed-time reset/run stimulus.
// - Sequences core reset, counts run cycles, detects halt (PC stuck) or cycle timeout, and logs recent fetches in a circular trace buffer.
// - Sits beside uP16_top: drives its active-high core reset, observes IF_currPC / IF_inst_d / EX_ALUstatus_d.
// PARAMETERS
// - PC_W        16     width of IF_currPC
// - INST_W      18     width of IF_inst_d
// - RST_HOLD    4      cycles core_rst held high after leaving reset/clear (>=1)
// - HALT_CYC    8      consecutive cycles of unchanged PC that signal halt (>=2)
// - TIMEOUT     50000  run cycles before forced stop (>=1, < 2^32)
// - TRACE_DEPTH 16     trace entries, power of two (>=2); AW = log2(TRACE_DEPTH)
// PORTS
// - Clk            in   1          system clock, rising edge
// - Rst_n          in   1          asynchronous active-low reset
// - clear          in   1          sync restart: back to HOLD, counters/trace cleared
// - IF_currPC      in   PC_W       core fetch PC
// - IF_inst_d      in   INST_W     core fetched instruction
// - EX_ALUstatus_d in   4          core EX-stage ALU flags
// - trace_rd_addr  in   AW         trace read index, 0 = oldest valid entry
// - core_rst       out  1          active-high reset to uP16_top
// - running        out  1          state == RUN
// - halted         out  1          sticky: halt detected
// - timed_out      out  1          sticky: TIMEOUT reached
// - cycle_count    out  32         RUN cycles elapsed
// - trace_count    out  AW+1       valid entries, saturates at TRACE_DEPTH
// - trace_rd_data  out  PC_W+INST_W  {PC, inst} at trace_rd_addr, combinational read
// - alu_flags_seen out  4          sticky OR of ALU flags (see CONFIGURATION)
// BEHAVIOUR
// - Reset (Rst_n=0, async): state=HOLD, core_rst=1, running=0, halted=0, timed_out=0, cycle_count=0, trace_count=0, wr_ptr=0, hold counter=0, stable counter=0, alu_flags_seen=0.
// - FSM HOLD -> RUN -> {HALT | TIMEOUT}; HALT and TIMEOUT are terminal until clear or reset.
// - HOLD: core_rst=1; after RST_HOLD cycles in HOLD go RUN; core_rst registered, deasserts same edge RUN entered.
// - RUN: cycle_count +1 per cycle (saturates at 32'hFFFF_FFFF); prev_pc registered each cycle.
// - Halt: stable counter +1 when IF_currPC == prev_pc, else reset to 0; on reaching HALT_CYC-1 -> HALT, halted=1.
// - Timeout: when cycle_count == TIMEOUT-1 in RUN -> TIMEOUT, timed_out=1.
// - Halt and timeout same edge: HALT wins, halted=1, timed_out stays 0.
// - HALT/TIMEOUT: core_rst=1 (core frozen), cycle_count and trace frozen, outputs hold.
// - Trace write: in RUN, when IF_currPC != prev_pc or first RUN cycle, write {IF_currPC, IF_inst_d} at wr_ptr, wr_ptr+1 mod TRACE_DEPTH; trace_count +1 saturating.
// - Full buffer: overwrites oldest; read index maps to (wr_ptr - trace_count + trace_rd_addr) mod TRACE_DEPTH.
// - trace_rd_addr >= trace_count: trace_rd_data = 0.
// - clear (sync, any state): next state HOLD, all counters, sticky flags, trace_count, wr_ptr cleared; core_rst=1 next cycle. clear beats same-cycle halt/timeout.
// - Rst_n asserted mid-run: immediate return to reset values; trace contents undefined, trace_count=0 hides them.
// CONFIGURATION
// - UP16_MON_ALUFLAGS_EN defined: in RUN, alu_flags_seen <= alu_flags_seen | EX_ALUstatus_d; cleared by reset/clear, frozen in HALT/TIMEOUT.
// - Not defined: alu_flags_seen tied to 4'b0, no flag registers.
// TESTING
// - Release Rst_n, PC increments each cycle -> core_rst falls after 4 cycles, running=1, cycle_count increments by 1/cycle.
// - Core loops branch-to-self at PC=16'h0020 -> halted=1 after 8 stable cycles, running=0, core_rst=1, cycle_count frozen.
// - TIMEOUT=100, PC never stalls -> timed_out=1 at cycle_count=99, halted=0.
// - 20 distinct PCs 0..19 -> trace_count=16, addr 0 reads PC 4, addr 15 reads PC 19.
// - clear asserted in HALT -> halted=0, trace_count=0, HOLD 4 cycles, RUN again; Rst_n low mid-RUN -> all outputs to reset values same cycle.
// - UP16_MON_ALUFLAGS_EN: flags 4'b0001 then 4'b0100 -> alu_flags_seen=4'b0101; undefined -> stays 4'b0000.

Source files
------------

// File: rtl/up16_run_monitor.sv
// -----------------------------------------------------------------------------
// up16_run_monitor
//
// Run controller and trace monitor for the uP16 pipelined core. Holds the core
// in reset for RST_HOLD cycles, then lets it run while counting cycles. It stops
// the core when the fetch PC stays the same for HALT_CYC cycles (halt) or when
// TIMEOUT run cycles have elapsed. Every fetch of a new PC is logged into a
// circular trace buffer that can be read back, oldest entry first.
//
// Optional feature macro: UP16_MON_ALUFLAGS_EN
//   defined   -> alu_flags_seen is the sticky OR of EX_ALUstatus_d over RUN
//   undefined -> alu_flags_seen is tied to 4'b0000
//
// Ports
//   Clk            in   system clock, rising edge
//   Rst_n          in   asynchronous active-low reset
//   clear          in   synchronous restart: back to HOLD, counters/trace cleared
//   IF_currPC      in   core fetch PC
//   IF_inst_d      in   core fetched instruction
//   EX_ALUstatus_d in   core EX-stage ALU flags
//   trace_rd_addr  in   trace read index, 0 = oldest valid entry
//   core_rst       out  active-high reset to uP16_top
//   running        out  high while in RUN
//   halted         out  sticky: halt detected
//   timed_out      out  sticky: TIMEOUT reached
//   cycle_count    out  RUN cycles elapsed (saturating)
//   trace_count    out  valid trace entries, saturates at TRACE_DEPTH
//   trace_rd_data  out  {PC, inst} at trace_rd_addr, combinational, 0 if invalid
//   alu_flags_seen out  sticky OR of ALU flags (feature macro above)
// -----------------------------------------------------------------------------
module up16_run_monitor #(
  parameter int          PC_W        = 16,
  parameter int          INST_W      = 18,
  parameter int          RST_HOLD    = 4,
  parameter int          HALT_CYC    = 8,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int          TRACE_DEPTH = 16,
  localparam int         AW          = $clog2(TRACE_DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   clear,
  input  logic [PC_W-1:0]        IF_currPC,
  input  logic [INST_W-1:0]      IF_inst_d,
  input  logic [3:0]             EX_ALUstatus_d,
  input  logic [AW-1:0]          trace_rd_addr,
  output logic                   core_rst,
  output logic                   running,
  output logic                   halted,
  output logic                   timed_out,
  output logic [31:0]            cycle_count,
  output logic [AW:0]            trace_count,
  output logic [PC_W+INST_W-1:0] trace_rd_data,
  output logic [3:0]             alu_flags_seen
);

  localparam int TW = PC_W + INST_W;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int SW = $clog2(HALT_CYC);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] HALT_LAST  = SW'(HALT_CYC - 1);
  localparam logic [31:0]   TMO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [AW:0]   TRACE_FULL = (AW+1)'(TRACE_DEPTH);

  logic [1:0]      state_q,     state_d;
  logic            core_rst_q,  core_rst_d;
  logic [HW-1:0]   hold_cnt_q,  hold_cnt_d;
  logic [SW-1:0]   stable_q,    stable_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic            halted_q,    halted_d;
  logic            timed_out_q, timed_out_d;
  logic [PC_W-1:0] prev_pc_q,   prev_pc_d;
  logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [AW:0]     trace_cnt_q, trace_cnt_d;

  logic            trace_we;
  logic            pc_changed;
  logic [TW-1:0]   trace_mem [TRACE_DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    core_rst_d  = core_rst_q;
    hold_cnt_d  = hold_cnt_q;
    stable_d    = stable_q;
    cycle_cnt_d = cycle_cnt_q;
    halted_d    = halted_q;
    timed_out_d = timed_out_q;
    prev_pc_d   = prev_pc_q;
    wr_ptr_d    = wr_ptr_q;
    trace_cnt_d = trace_cnt_q;
    trace_we    = 1'b0;
    // cycle_count is 0 only in the first RUN cycle, whose fetch is always new;
    // this keeps a stale prev_pc from an earlier run out of the comparison.
    pc_changed  = (cycle_cnt_q == '0) || (IF_currPC != prev_pc_q);

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      ST_RUN: begin
        prev_pc_d = IF_currPC;
        stable_d  = pc_changed ? '0 : stable_q + SW'(1);

        if (pc_changed) begin
          trace_we = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (trace_cnt_q != TRACE_FULL) trace_cnt_d = trace_cnt_q + (AW+1)'(1);
        end

        // Halt has priority over a same-cycle timeout. The cycle that ends the
        // run is not counted, so a timeout leaves cycle_count at TIMEOUT-1.
        if (stable_d == HALT_LAST) begin
          state_d    = ST_HALT;
          halted_d   = 1'b1;
          core_rst_d = 1'b1;
        end else if (cycle_cnt_q == TMO_LAST) begin
          state_d     = ST_TIMEOUT;
          timed_out_d = 1'b1;
          core_rst_d  = 1'b1;
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
      end

      default: ;  // HALT / TIMEOUT: everything frozen until clear or reset
    endcase

    // clear overrides whatever the run logic decided this cycle.
    if (clear) begin
      state_d     = ST_HOLD;
      core_rst_d  = 1'b1;
      hold_cnt_d  = '0;
      stable_d    = '0;
      cycle_cnt_d = '0;
      halted_d    = 1'b0;
      timed_out_d = 1'b0;
      wr_ptr_d    = '0;
      trace_cnt_d = '0;
      trace_we    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_HOLD;
      core_rst_q  <= 1'b1;
      hold_cnt_q  <= '0;
      stable_q    <= '0;
      cycle_cnt_q <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      prev_pc_q   <= '0;
      wr_ptr_q    <= '0;
      trace_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= core_rst_d;
      hold_cnt_q  <= hold_cnt_d;
      stable_q    <= stable_d;
      cycle_cnt_q <= cycle_cnt_d;
      halted_q    <= halted_d;
      timed_out_q <= timed_out_d;
      prev_pc_q   <= prev_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      trace_cnt_q <= trace_cnt_d;
    end
  end

  // NOTE: the trace storage has no reset; trace_count = 0 hides stale entries,
  // which lets the array map onto plain RAM.
  always_ff @(posedge Clk) begin
    if (trace_we) trace_mem[wr_ptr_q] <= {IF_currPC, IF_inst_d};
  end

  // ---------------------------------------------------------------------------
  // Trace read: index 0 is the oldest valid entry.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] rd_idx;
  logic          rd_valid;

  assign rd_idx        = wr_ptr_q - trace_cnt_q[AW-1:0] + trace_rd_addr;
  assign rd_valid      = {1'b0, trace_rd_addr} < trace_cnt_q;
  assign trace_rd_data = rd_valid ? trace_mem[rd_idx] : '0;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign core_rst    = core_rst_q;
  assign running     = (state_q == ST_RUN);
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_cnt_q;
  assign trace_count = trace_cnt_q;

`ifdef UP16_MON_ALUFLAGS_EN
  logic [3:0] alu_flags_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 alu_flags_q <= 4'b0;
    else if (clear)             alu_flags_q <= 4'b0;
    else if (state_q == ST_RUN) alu_flags_q <= alu_flags_q | EX_ALUstatus_d;
  end

  assign alu_flags_seen = alu_flags_q;
`else
  logic unused_alu_status;

  assign unused_alu_status = ^EX_ALUstatus_d;
  assign alu_flags_seen    = 4'b0;
`endif

endmodule

// File: tb/tb_up16_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_up16_run_monitor
//
// Directed bench for up16_run_monitor (TIMEOUT = 100, other parameters at
// their defaults). Inputs change 1 ns after the rising edge and outputs are
// sampled at that same point, so every observation reflects the last edge.
// -----------------------------------------------------------------------------
module tb_up16_run_monitor;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        clear;
  logic [15:0] IF_currPC;
  logic [17:0] IF_inst_d;
  logic [3:0]  EX_ALUstatus_d;
  logic [3:0]  trace_rd_addr;
  logic        core_rst;
  logic        running;
  logic        halted;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic [4:0]  trace_count;
  logic [33:0] trace_rd_data;
  logic [3:0]  alu_flags_seen;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef UP16_MON_ALUFLAGS_EN
  localparam logic [3:0] EXP_FLAGS = 4'b0101;
`else
  localparam logic [3:0] EXP_FLAGS = 4'b0000;
`endif

  localparam logic [78:0] RESET_VEC = {4'b1000, 32'd0, 5'd0, 4'd0, 34'd0};

  always #5 Clk = ~Clk;

  up16_run_monitor #(.TIMEOUT(100)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .clear          (clear),
    .IF_currPC      (IF_currPC),
    .IF_inst_d      (IF_inst_d),
    .EX_ALUstatus_d (EX_ALUstatus_d),
    .trace_rd_addr  (trace_rd_addr),
    .core_rst       (core_rst),
    .running        (running),
    .halted         (halted),
    .timed_out      (timed_out),
    .cycle_count    (cycle_count),
    .trace_count    (trace_count),
    .trace_rd_data  (trace_rd_data),
    .alu_flags_seen (alu_flags_seen)
  );

  // Expected trace entry for a fetch of PC p (instruction derived from p).
  function automatic logic [33:0] ent(input logic [15:0] p);
    return {p, p[1:0], ~p};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_pc(input logic [15:0] p);
    IF_currPC = p;
    IF_inst_d = {p[1:0], ~p};
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic hold_phase(input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (running !== (k == 4) || core_rst !== (k != 4)) begin
        n_mis++;
        $display("FAIL %s_hold%0d: got run=%b rst=%b want run=%b rst=%b",
                 tag, k, running, core_rst, (k == 4), (k != 4));
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; clear = 1'b0; EX_ALUstatus_d = 4'b0; trace_rd_addr = 4'd0;
    drive_pc(16'h0100);
    #12;
    n_cmp++;
    if ({core_rst, running, halted, timed_out, cycle_count, trace_count,
         alu_flags_seen, trace_rd_data} !== RESET_VEC) begin
      n_mis++;
      $display("FAIL reset_vals: got %h want %h",
               {core_rst, running, halted, timed_out, cycle_count, trace_count,
                alu_flags_seen, trace_rd_data}, RESET_VEC);
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_run();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (core_rst !== (k < 4) || running !== (k == 4) || cycle_count !== 32'd0) begin
        n_mis++;
        $display("FAIL run_hold%0d: got rst=%b run=%b cc=%0d want rst=%b run=%b cc=0",
                 k, core_rst, running, cycle_count, (k < 4), (k == 4));
      end
      drive_pc(16'h0100 + 16'(k));
    end
    for (int k = 5; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (cycle_count !== 32'(k - 4) || trace_count !== 5'(k - 4)) begin
        n_mis++;
        $display("FAIL run_count%0d: got cc=%0d tc=%0d want %0d", k,
                 cycle_count, trace_count, k - 4);
      end
      if (k < 10) drive_pc(16'h0100 + 16'(k));
    end
    trace_rd_addr = 4'd0; #1;
    n_cmp++;
    if (trace_rd_data !== ent(16'h0104)) begin
      n_mis++;
      $display("FAIL run_trace0: got %h want %h", trace_rd_data, ent(16'h0104));
    end
    trace_rd_addr = 4'd5; #1;
    n_cmp++;
    if (trace_rd_data !== ent(16'h0109)) begin
      n_mis++;
      $display("FAIL run_trace5: got %h want %h", trace_rd_data, ent(16'h0109));
    end
    trace_rd_addr = 4'd6; #1;
    n_cmp++;
    if (trace_rd_data !== 34'd0) begin
      n_mis++;
      $display("FAIL run_trace_invalid: got %h want 0", trace_rd_data);
    end
  endtask

  task automatic test_halt();
    drive_pc(16'h0020);
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++;
      if (running !== 1'b1 || halted !== 1'b0) begin
        n_mis++;
        $display("FAIL halt_early%0d: got run=%b halted=%b want run=1 halted=0",
                 i, running, halted);
      end
    end
    tick();
    n_cmp++;
    if ({halted, running, core_rst, timed_out} !== 4'b1010) begin
      n_mis++;
      $display("FAIL halt_flags: got %b want 1010", {halted, running, core_rst, timed_out});
    end
    n_cmp++;
    if (cycle_count !== 32'd13 || trace_count !== 5'd7) begin
      n_mis++;
      $display("FAIL halt_counts: got cc=%0d tc=%0d want cc=13 tc=7", cycle_count, trace_count);
    end
    drive_pc(16'h0300);
    repeat (3) tick();
    n_cmp++;
    if (cycle_count !== 32'd13 || trace_count !== 5'd7 || halted !== 1'b1) begin
      n_mis++;
      $display("FAIL halt_frozen: got cc=%0d tc=%0d h=%b want cc=13 tc=7 h=1",
               cycle_count, trace_count, halted);
    end
  endtask

  task automatic test_clear_and_trace();
    pulse_clear();
    trace_rd_addr = 4'd0; #1;
    n_cmp++;
    if ({halted, running, core_rst} !== 3'b001 || cycle_count !== 32'd0 ||
        trace_count !== 5'd0 || trace_rd_data !== 34'd0) begin
      n_mis++;
      $display("FAIL clear_vals: got hrc=%b cc=%0d tc=%0d rd=%h want 001/0/0/0",
               {halted, running, core_rst}, cycle_count, trace_count, trace_rd_data);
    end
    drive_pc(16'h0500);
    hold_phase("clear");
    drive_pc(16'h0000);
    for (int i = 1; i <= 19; i++) begin
      tick();
      drive_pc(16'(i));
    end
    tick();
    n_cmp++;
    if (trace_count !== 5'd16 || cycle_count !== 32'd20) begin
      n_mis++;
      $display("FAIL trace_count: got tc=%0d cc=%0d want tc=16 cc=20", trace_count, cycle_count);
    end
    trace_rd_addr = 4'd0; #1;
    n_cmp++;
    if (trace_rd_data !== ent(16'd4)) begin
      n_mis++;
      $display("FAIL trace_oldest: got %h want %h", trace_rd_data, ent(16'd4));
    end
    trace_rd_addr = 4'd15; #1;
    n_cmp++;
    if (trace_rd_data !== ent(16'd19)) begin
      n_mis++;
      $display("FAIL trace_newest: got %h want %h", trace_rd_data, ent(16'd19));
    end
    trace_rd_addr = 4'd7; #1;
    n_cmp++;
    if (trace_rd_data !== ent(16'd11)) begin
      n_mis++;
      $display("FAIL trace_mid: got %h want %h", trace_rd_data, ent(16'd11));
    end
    trace_rd_addr = 4'd0;
  endtask

  task automatic test_timeout();
    pulse_clear();
    drive_pc(16'h1000);
    hold_phase("tmo");
    drive_pc(16'h2000);
    for (int t = 1; t <= 99; t++) begin
      tick();
      drive_pc(16'h2000 + 16'(t));
    end
    n_cmp++;
    if (cycle_count !== 32'd99 || running !== 1'b1 || timed_out !== 1'b0) begin
      n_mis++;
      $display("FAIL tmo_before: got cc=%0d run=%b to=%b want cc=99 run=1 to=0",
               cycle_count, running, timed_out);
    end
    tick();
    n_cmp++;
    if ({timed_out, halted, running, core_rst} !== 4'b1001 || cycle_count !== 32'd99) begin
      n_mis++;
      $display("FAIL tmo_hit: got flags=%b cc=%0d want flags=1001 cc=99",
               {timed_out, halted, running, core_rst}, cycle_count);
    end
    repeat (2) tick();
    n_cmp++;
    if (cycle_count !== 32'd99 || trace_count !== 5'd16 || timed_out !== 1'b1) begin
      n_mis++;
      $display("FAIL tmo_frozen: got cc=%0d tc=%0d to=%b want cc=99 tc=16 to=1",
               cycle_count, trace_count, timed_out);
    end
  endtask

  task automatic test_halt_timeout_tie();
    pulse_clear();
    hold_phase("tie");
    drive_pc(16'h3000);
    for (int t = 1; t <= 92; t++) begin
      tick();
      drive_pc(16'h3000 + 16'(t));
    end
    repeat (7) tick();
    n_cmp++;
    if (cycle_count !== 32'd99 || running !== 1'b1) begin
      n_mis++;
      $display("FAIL tie_before: got cc=%0d run=%b want cc=99 run=1", cycle_count, running);
    end
    tick();
    n_cmp++;
    if ({halted, timed_out, running} !== 3'b100 || cycle_count !== 32'd99) begin
      n_mis++;
      $display("FAIL tie_halt_wins: got h/to/run=%b cc=%0d want 100 cc=99",
               {halted, timed_out, running}, cycle_count);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_clear();
    hold_phase("mid");
    EX_ALUstatus_d = 4'b1111;
    for (int t = 1; t <= 3; t++) begin
      drive_pc(16'h0600 + 16'(t));
      tick();
    end
    EX_ALUstatus_d = 4'b0000;
    n_cmp++;
    if (running !== 1'b1 || cycle_count !== 32'd3) begin
      n_mis++;
      $display("FAIL mid_pre: got run=%b cc=%0d want run=1 cc=3", running, cycle_count);
    end
    Rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({core_rst, running, halted, timed_out, cycle_count, trace_count,
         alu_flags_seen, trace_rd_data} !== RESET_VEC) begin
      n_mis++;
      $display("FAIL mid_reset_vals: got %h want %h",
               {core_rst, running, halted, timed_out, cycle_count, trace_count,
                alu_flags_seen, trace_rd_data}, RESET_VEC);
    end
    #20;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_alu_flags();
    EX_ALUstatus_d = 4'b1000;   // seen only during HOLD, must not be captured
    drive_pc(16'h0700);
    hold_phase("alu");
    drive_pc(16'h4000);
    EX_ALUstatus_d = 4'b0001;
    tick();
    EX_ALUstatus_d = 4'b0100;
    tick();
    EX_ALUstatus_d = 4'b0000;
    tick();
    n_cmp++;
    if (alu_flags_seen !== EXP_FLAGS) begin
      n_mis++;
      $display("FAIL alu_or: got %b want %b", alu_flags_seen, EXP_FLAGS);
    end
    repeat (5) tick();
    n_cmp++;
    if (halted !== 1'b1) begin
      n_mis++;
      $display("FAIL alu_halt: got halted=%b want 1", halted);
    end
    EX_ALUstatus_d = 4'b1000;
    repeat (2) tick();
    n_cmp++;
    if (alu_flags_seen !== EXP_FLAGS) begin
      n_mis++;
      $display("FAIL alu_frozen: got %b want %b", alu_flags_seen, EXP_FLAGS);
    end
    pulse_clear();
    n_cmp++;
    if (alu_flags_seen !== 4'b0000) begin
      n_mis++;
      $display("FAIL alu_clear: got %b want 0000", alu_flags_seen);
    end
    EX_ALUstatus_d = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_run();
    test_halt();
    test_clear_and_trace();
    test_timeout();
    test_halt_timeout_tie();
    test_reset_midrun();
    test_alu_flags();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
